fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage pipeline. Owns the PC register and drives
//  a ready/request instruction-memory port, then loads the IF/ID pipeline register

---
 rtl/fetch_stage.sv | 218 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ready instruction-memory port
// and loads the IF/ID register, honouring decode stalls and execute-stage redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc_f;
    logic [31:0] r_redir_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_buf_pc_plus4;
    logic [31:0] w_pc_next;
    logic [31:0] w_redir_next;
    logic        w_in_fetch;
    logic        w_in_hold;
    logic        w_in_discard;
    logic        w_buf_load;
    logic        w_load_fetch;
    logic        w_load_hold;

    // Wrap-around modulo 2^32 is the natural behaviour of the 32-bit adders.
    assign w_pc_plus4     = r_pc_f + 32'd4;
    assign w_buf_pc_plus4 = r_buf_pc + 32'd4;

    assign w_in_fetch   = (r_state == S_FETCH);
    assign w_in_hold    = (r_state == S_HOLD);
    assign w_in_discard = (r_state == S_DISCARD);

    assign w_buf_load   = w_in_fetch & imem_ready & stall_d & ~pc_src_e;
    assign w_load_fetch = w_in_fetch & imem_ready & ~stall_d & ~pc_src_e;
    assign w_load_hold  = w_in_hold & ~stall_d & ~pc_src_e;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_FETCH: begin
                if (pc_src_e && !imem_ready) begin
                    w_state_next = S_DISCARD;
                end else if (imem_ready && stall_d && !pc_src_e) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (pc_src_e || !stall_d) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (imem_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: memory-port outputs
    // ------------------------------------------------------------------
    // The request is gated by reset itself so it is withdrawn the instant reset
    // asserts, without waiting for a clock edge.
    always_comb begin
        imem_req  = reset & ~w_in_hold;
        imem_addr = r_pc_f;
    end

    // ------------------------------------------------------------------
    // PC and redirect-target next values
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_next    = r_pc_f;
        w_redir_next = r_redir_pc;
        unique case (r_state)
            S_FETCH: begin
                if (pc_src_e && imem_ready) begin
                    w_pc_next = pc_target_e;
                end else if (pc_src_e) begin
                    w_redir_next = pc_target_e;
                end else if (imem_ready) begin
                    w_pc_next = w_pc_plus4;
                end
            end
            S_HOLD: begin
                if (pc_src_e) begin
                    w_pc_next = pc_target_e;
                end
            end
            S_DISCARD: begin
                if (pc_src_e) begin
                    w_redir_next = pc_target_e;
                end
                if (imem_ready) begin
                    w_pc_next = pc_src_e ? pc_target_e : r_redir_pc;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the skid buffer and redirect holder are reset along with the PC;
    // they are single registers, not a memory array, so the reset is cheap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_f      <= RESET_PC;
            r_redir_pc  <= RESET_PC;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc    <= 32'd0;
        end else begin
            r_pc_f     <= w_pc_next;
            r_redir_pc <= w_redir_next;
            if (w_buf_load) begin
                r_buf_instr <= imem_rdata;
                r_buf_pc    <= r_pc_f;
            end
        end
    end

    // IF/ID register: redirect flush beats stall, stall beats load, else bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else if (pc_src_e) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (stall_d) begin
            r_instr_d    <= r_instr_d;
            r_pc_d       <= r_pc_d;
            r_pc_plus4_d <= r_pc_plus4_d;
            r_valid_d    <= r_valid_d;
        end else if (w_load_fetch) begin
            r_instr_d    <= imem_rdata;
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
        end else if (w_load_hold) begin
            r_instr_d    <= r_buf_instr;
            r_pc_d       <= r_buf_pc;
            r_pc_plus4_d <= w_buf_pc_plus4;
            r_valid_d    <= 1'b1;
        end else begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end
    end

    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign valid_d    = r_valid_d;

    // A pending request must keep its address until memory accepts it.
    a_addr_stable : assert property (
        @(posedge clk) disable iff (!reset)
        (imem_req && !imem_ready) |=> $stable(imem_addr)
    );

    a_bubble_is_nop : assert property (
        @(posedge clk) disable iff (!reset)
        !valid_d |-> (instr_d == NOP_INSTR)
    );

    a_no_req_in_hold : assert property (
        @(posedge clk) disable iff (!reset)
        w_in_hold |-> !imem_req
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle vector table plus scoreboard of
// delivered instructions, and a hand-written asynchronous-reset sequence.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        ready;
        logic        stall;
        logic        src;
        logic [31:0] tgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] dpc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .stall_d    (stall_d),
        .pc_src_e   (pc_src_e),
        .pc_target_e(pc_target_e),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d)
    );

    // Memory model: word at address a is 0x100 + a/4.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h100 + {2'b00, a[31:2]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic s, input logic p,
                                input logic [31:0] t, input logic req,
                                input logic [31:0] a, input logic v,
                                input logic [31:0] dpc);
        vec_t x;
        x.ready     = r;
        x.stall     = s;
        x.src       = p;
        x.tgt       = t;
        x.exp_req   = req;
        x.exp_addr  = a;
        x.exp_valid = v;
        x.dpc       = dpc;
        vecs.push_back(x);
    endfunction

    // Called at posedge+1: drive, check port outputs, clock, check IF/ID.
    task automatic step(input vec_t v, input int idx);
        logic [31:0] exp_pc;
        imem_ready  = v.ready;
        stall_d     = v.stall;
        pc_src_e    = v.src;
        pc_target_e = v.tgt;
        if (v.exp_valid && !v.stall) sb_q.push_back(v.dpc);
        #1;
        check($sformatf("v%0d imem_req", idx), {31'd0, imem_req}, {31'd0, v.exp_req});
        if (v.exp_req) check($sformatf("v%0d imem_addr", idx), imem_addr, v.exp_addr);
        @(posedge clk);
        #1;
        check($sformatf("v%0d valid_d", idx), {31'd0, valid_d}, {31'd0, v.exp_valid});
        if (!valid_d) check($sformatf("v%0d bubble instr_d", idx), instr_d, NOP_INSTR);
        if (valid_d && !v.stall) begin
            if (sb_q.size() == 0) begin
                check($sformatf("v%0d unexpected delivery pc_d", idx), pc_d, 32'hDEAD_BEEF);
            end else begin
                exp_pc = sb_q.pop_front();
                check($sformatf("v%0d pc_d", idx), pc_d, exp_pc);
                check($sformatf("v%0d instr_d", idx), instr_d, mem_word(exp_pc));
                check($sformatf("v%0d pc_plus4_d", idx), pc_plus4_d, exp_pc + 32'd4);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, " imem_addr"}, imem_addr, RESET_PC);
        check({tag, " valid_d"}, {31'd0, valid_d}, 32'd0);
        check({tag, " instr_d"}, instr_d, NOP_INSTR);
        check({tag, " pc_d"}, pc_d, 32'd0);
        check({tag, " pc_plus4_d"}, pc_plus4_d, 32'd0);
    endtask

    initial begin
        vec_t v;
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        stall_d     = 1'b0;
        pc_src_e    = 1'b0;
        pc_target_e = 32'd0;

        //  ready stall src target        req addr          valid delivered-pc
        // zero-wait streaming, then three wait cycles at pc 8
        add(1, 0, 0, 0,             1, 32'h0,         1, 32'h0);
        add(1, 0, 0, 0,             1, 32'h4,         1, 32'h4);
        add(0, 0, 0, 0,             1, 32'h8,         0, 0);
        add(0, 0, 0, 0,             1, 32'h8,         0, 0);
        add(0, 0, 0, 0,             1, 32'h8,         0, 0);
        add(1, 0, 0, 0,             1, 32'h8,         1, 32'h8);
        add(1, 0, 0, 0,             1, 32'hC,         1, 32'hC);
        // two-cycle decode stall with a word arriving: buffered, then released
        add(1, 1, 0, 0,             1, 32'h10,        1, 0);
        add(1, 1, 0, 0,             0, 0,             1, 0);
        add(1, 0, 0, 0,             0, 0,             1, 32'h10);
        add(1, 0, 0, 0,             1, 32'h14,        1, 32'h14);
        // redirect during a wait: address held, old word dropped
        add(0, 0, 1, 32'h40,        1, 32'h18,        0, 0);
        add(0, 0, 0, 0,             1, 32'h18,        0, 0);
        add(1, 0, 0, 0,             1, 32'h18,        0, 0);
        add(1, 0, 0, 0,             1, 32'h40,        1, 32'h40);
        // repeated redirects while discarding: latest target wins
        add(0, 0, 1, 32'h80,        1, 32'h44,        0, 0);
        add(0, 0, 1, 32'hC0,        1, 32'h44,        0, 0);
        add(1, 0, 0, 0,             1, 32'h44,        0, 0);
        add(1, 0, 0, 0,             1, 32'hC0,        1, 32'hC0);
        // redirect with zero-wait memory
        add(1, 0, 1, 32'h200,       1, 32'hC4,        0, 0);
        add(1, 0, 0, 0,             1, 32'h200,       1, 32'h200);
        // redirect together with stall
        add(1, 1, 1, 32'h300,       1, 32'h204,       0, 0);
        add(1, 0, 0, 0,             1, 32'h300,       1, 32'h300);
        // redirect while holding a buffered word: buffer dropped
        add(1, 1, 0, 0,             1, 32'h304,       1, 0);
        add(1, 1, 1, 32'h400,       0, 0,             0, 0);
        add(1, 0, 0, 0,             1, 32'h400,       1, 32'h400);
        // redirect while discarding with memory ready the same cycle
        add(0, 0, 1, 32'h500,       1, 32'h404,       0, 0);
        add(1, 0, 1, 32'h600,       1, 32'h404,       0, 0);
        add(1, 0, 0, 0,             1, 32'h600,       1, 32'h600);
        // pc wrap at the top of the address space
        add(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h604,       0, 0);
        add(1, 0, 0, 0,             1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        add(1, 0, 0, 0,             1, 32'h0,         1, 32'h0);
        add(0, 0, 0, 0,             1, 32'h4,         0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("initial reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end
        check("table scoreboard empty", sb_q.size(), 32'd0);

        // Asynchronous reset in the middle of a wait, away from any clock edge.
        imem_ready = 1'b0;
        #2;
        check("pre-reset imem_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(posedge clk);
        #1;
        check("reset held imem_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("post-reset imem_req", {31'd0, imem_req}, 32'd1);
        check("post-reset imem_addr", imem_addr, RESET_PC);
        v.ready = 1; v.stall = 0; v.src = 0; v.tgt = 0;
        v.exp_req = 1; v.exp_addr = RESET_PC; v.exp_valid = 1; v.dpc = RESET_PC;
        @(posedge clk);
        #1;
        step(v, 100);
        v.exp_addr = RESET_PC + 32'd4; v.dpc = RESET_PC + 32'd4;
        step(v, 101);
        check("final scoreboard empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
